// File: rtl/core_pkg.sv
// Shared hazard/forwarding definitions: FSM states, forwarding select codes,
// opcode constants and the producer-match helper.
package core_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned FWD_SEL_W = 3;
    localparam int unsigned CNT_W     = 2;

    localparam logic [FWD_SEL_W-1:0] FWD_REGFILE = 3'd0;
    localparam logic [FWD_SEL_W-1:0] FWD_MEM     = 3'd1;
    localparam logic [FWD_SEL_W-1:0] FWD_WB      = 3'd2;
    localparam logic [FWD_SEL_W-1:0] FWD_HIST0   = 3'd3;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } hz_state_e;

    // x0 is hardwired zero, so a producer targeting it never forwards.
    function automatic logic prod_match(input logic                 wr_en,
                                        input logic [REG_IDX_W-1:0] rd,
                                        input logic [REG_IDX_W-1:0] rs);
        return wr_en && (rd == rs) && (rd != '0);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding select for a single EX operand:
// MEM > WB > history[0..HIST_DEPTH-1] > register-file value.
module fwd_mux
    import core_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HIST_DEPTH = 1,
    parameter int unsigned HD         = 1
) (
    input  logic [REG_IDX_W-1:0]          rs_i,
    input  logic [XLEN-1:0]               rdata_i,
    input  logic                          mem_wr_en_i,
    input  logic [REG_IDX_W-1:0]          mem_rd_i,
    input  logic [XLEN-1:0]               mem_data_i,
    input  logic                          wb_wr_en_i,
    input  logic [REG_IDX_W-1:0]          wb_rd_i,
    input  logic [XLEN-1:0]               wb_data_i,
    input  logic [HD-1:0]                 hist_en_i,
    input  logic [HD-1:0][REG_IDX_W-1:0]  hist_rd_i,
    input  logic [HD-1:0][XLEN-1:0]       hist_data_i,
    output logic [XLEN-1:0]               opnd_o,
    output logic [FWD_SEL_W-1:0]          sel_o
);

    logic found;

    always_comb begin
        opnd_o = rdata_i;
        sel_o  = FWD_REGFILE;
        found  = 1'b0;
        if (prod_match(mem_wr_en_i, mem_rd_i, rs_i)) begin
            opnd_o = mem_data_i;
            sel_o  = FWD_MEM;
            found  = 1'b1;
        end else if (prod_match(wb_wr_en_i, wb_rd_i, rs_i)) begin
            opnd_o = wb_data_i;
            sel_o  = FWD_WB;
            found  = 1'b1;
        end
        for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
            if (!found && prod_match(hist_en_i[i], hist_rd_i[i], rs_i)) begin
                opnd_o = hist_data_i[i];
                sel_o  = FWD_HIST0 + FWD_SEL_W'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding, load-use stall and branch flush control.
// HAZARD_PERF_CNT_EN enables saturating stall/flush cycle counters.
module hazard_fwd_unit
    import core_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NSRC         = 2,
    parameter int unsigned HIST_DEPTH   = 1,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NSRC*REG_IDX_W-1:0] id_rs_i,
    input  logic [NSRC-1:0]           id_rs_used_i,
    input  logic [NSRC*REG_IDX_W-1:0] ex_rs_i,
    input  logic [NSRC*XLEN-1:0]      ex_rdata_i,
    input  logic [REG_IDX_W-1:0]      ex_rd_i,
    input  logic                      ex_wr_en_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_IDX_W-1:0]      mem_rd_i,
    input  logic                      mem_wr_en_i,
    input  logic [XLEN-1:0]           mem_data_i,
    input  logic [REG_IDX_W-1:0]      wb_rd_i,
    input  logic                      wb_wr_en_i,
    input  logic [XLEN-1:0]           wb_data_i,
    input  logic                      branch_taken_i,
    output logic [NSRC*XLEN-1:0]      ex_opnd_o,
    output logic [NSRC*FWD_SEL_W-1:0] fwd_sel_o,
    output logic                      stall_o,
    output logic                      bubble_o,
    output logic                      flush_o,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               flush_cnt_o
);

    localparam int unsigned HD        = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;
    localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_CYCLES - 1);

    logic [HD-1:0]                hist_en_q;
    logic [HD-1:0][REG_IDX_W-1:0] hist_rd_q;
    logic [HD-1:0][XLEN-1:0]      hist_data_q;

    if (HIST_DEPTH > 0) begin : g_hist
        always_ff @(posedge clk) begin
            if (rst_n) begin
                hist_en_q   <= '0;
                hist_rd_q   <= '0;
                hist_data_q <= '0;
            end else begin
                hist_en_q[0]   <= wb_wr_en_i;
                hist_rd_q[0]   <= wb_rd_i;
                hist_data_q[0] <= wb_data_i;
                for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
                    hist_en_q[k]   <= hist_en_q[k-1];
                    hist_rd_q[k]   <= hist_rd_q[k-1];
                    hist_data_q[k] <= hist_data_q[k-1];
                end
            end
        end
    end else begin : g_nohist
        assign hist_en_q   = '0;
        assign hist_rd_q   = '0;
        assign hist_data_q = '0;
    end

    for (genvar j = 0; j < NSRC; j++) begin : g_fwd
        fwd_mux #(
            .XLEN       (XLEN),
            .HIST_DEPTH (HIST_DEPTH),
            .HD         (HD)
        ) u_fwd_mux (
            .rs_i        (ex_rs_i[j*REG_IDX_W +: REG_IDX_W]),
            .rdata_i     (ex_rdata_i[j*XLEN +: XLEN]),
            .mem_wr_en_i (mem_wr_en_i),
            .mem_rd_i    (mem_rd_i),
            .mem_data_i  (mem_data_i),
            .wb_wr_en_i  (wb_wr_en_i),
            .wb_rd_i     (wb_rd_i),
            .wb_data_i   (wb_data_i),
            .hist_en_i   (hist_en_q),
            .hist_rd_i   (hist_rd_q),
            .hist_data_i (hist_data_q),
            .opnd_o      (ex_opnd_o[j*XLEN +: XLEN]),
            .sel_o       (fwd_sel_o[j*FWD_SEL_W +: FWD_SEL_W])
        );
    end

    logic load_use;

    always_comb begin
        load_use = 1'b0;
        for (int unsigned j = 0; j < NSRC; j++) begin
            if (id_rs_used_i[j] &&
                prod_match(ex_wr_en_i, ex_rd_i, id_rs_i[j*REG_IDX_W +: REG_IDX_W]))
                load_use = 1'b1;
        end
        load_use = load_use & ex_is_load_i;
    end

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall, bubble, flush;

    // cnt_q counts the STALL/FLUSH cycles still owed, including the current one;
    // the RUN-state detecting cycle is the first of the total.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        if (branch_taken_i) begin
            flush  = 1'b1;
            bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_CNT;
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_use) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = LOAD_CNT;
                        end
                    end
                end
                ST_STALL, ST_FLUSH: begin
                    stall  = (state_q == ST_STALL);
                    flush  = (state_q == ST_FLUSH);
                    bubble = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_o  = stall  & ~rst_n;
    assign bubble_o = bubble & ~rst_n;
    assign flush_o  = flush  & ~rst_n;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_o && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter NSRC, default 2, source operands per instruction (1..3).
REQ-003 Parameter HIST_DEPTH, default 1, completed-writeback entries retained after WB (0..4).
REQ-004 Parameter LOAD_LAT, default 1, load-use stall cycles (1..4).
REQ-005 Parameter FLUSH_CYCLES, default 2, bubbles issued after a taken branch (1..4).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  one clock; reset is synchronous and active-high (1 = reset, sampled on clk rising edge).
REQ-008 id_rs_i  input  NSRC*5  decode-stage source register indices.
REQ-009 id_rs_used_i  input  NSRC  per-source "operand actually read" flags.
REQ-010 ex_rs_i  input  NSRC*5  execute-stage source indices; ex_rdata_i  input  NSRC*XLEN  regfile values carried into EX.
REQ-011 ex_rd_i  input  5, ex_wr_en_i  input  1, ex_is_load_i  input  1  execute-stage producer.
REQ-012 mem_rd_i  input  5, mem_wr_en_i  input  1, mem_data_i  input  XLEN  memory-stage producer (ALU result).
REQ-013 wb_rd_i  input  5, wb_wr_en_i  input  1, wb_data_i  input  XLEN  writeback producer (ALU or load data).
REQ-014 branch_taken_i  input  1  branch resolved taken this cycle.
REQ-015 ex_opnd_o  output  NSRC*XLEN  forwarded EX operands; fwd_sel_o  output  NSRC*3  selected source per operand (0 regfile, 1 MEM, 2 WB, 3+k history k).
REQ-016 stall_o  output  1  hold PC and IF/ID; bubble_o  output  1  replace ID/EX with NOP; flush_o  output  1  invalidate IF/ID.

Function
REQ-017 Forwarding combinational: per operand, youngest match wins: MEM > WB > history[0] > ... > history[HIST_DEPTH-1] > ex_rdata_i.
REQ-018 A producer matches only if its wr_en=1, rd==operand index, rd!=0; index 0 SHALL always select regfile value.
REQ-019 History: shift register of {wr_en, rd, data}; each cycle history[0]<=WB inputs, history[k]<=history[k-1]; entries not gated by stall.
REQ-020 FSM states RUN, STALL, FLUSH; RUN is reset state.
REQ-021 RUN->STALL when ex_is_load_i & ex_wr_en_i & ex_rd_i!=0 & ex_rd_i equals any id_rs_i[j] with id_rs_used_i[j]=1; counter loads LOAD_LAT-1.
REQ-022 stall_o=bubble_o=1 in the detecting cycle and every STALL cycle: total LOAD_LAT cycles; STALL->RUN when counter=0 else decrement.
REQ-023 branch_taken_i=1 in any state -> FLUSH, counter loads FLUSH_CYCLES-1; flush_o=bubble_o=1 that cycle and each FLUSH cycle (FLUSH_CYCLES total); stall_o=0; pending stall discarded.
REQ-024 Branch during FLUSH restarts flush count; load-use detection suppressed during FLUSH.
REQ-025 FLUSH->RUN at counter 0; load-use detected in that exit cycle is not acted on until next RUN cycle.

Reset
REQ-026 While rst_n=1: state RUN, counters 0, history wr_en all 0; stall_o, bubble_o, flush_o 0 from the first cycle after; ex_opnd_o follows REQ-017 with empty history.
REQ-027 Reset asserted mid-STALL or mid-FLUSH aborts it; no residual bubble after release.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: outputs stall_cnt_o and flush_cnt_o (32 bit each) count cycles with stall_o=1 / flush_o=1, saturating at 0xFFFFFFFF, cleared by reset.
REQ-029 Macro undefined: both ports present, tied to 0, no counter flops.

Structure
REQ-030 Shared package core_pkg holds state enum, FWD_* select encodings, opcode constants, REG_IDX_W=5.
REQ-031 Single sub-module fwd_mux (one operand's priority select), instantiated NSRC times via generate.

Verification
REQ-032 MEM rd=1 data 0x11, WB rd=1 data 0x22, ex_rs=1 -> ex_opnd=0x11, fwd_sel=1.
REQ-033 Only history[0] rd=5 data 0xABCD (HIST_DEPTH=1), ex_rs2=5 -> ex_opnd[1]=0xABCD, sel=3; ex_rs=0 with MEM rd=0 wr_en=1 -> regfile value.
REQ-034 LOAD_LAT=3, EX load rd=7, id_rs1=7 used -> stall_o=bubble_o=1 exactly 3 cycles, then 0; same with id_rs_used=0 -> no stall.
REQ-035 Branch taken in 2nd stall cycle (FLUSH_CYCLES=2) -> stall_o drops next cycle, flush_o=1 for 2 cycles, then RUN.
REQ-036 Reset pulse during FLUSH -> all control outputs 0 next cycle; with HAZARD_PERF_CNT_EN, counters read 0 and a 4-cycle stall yields stall_cnt_o=4.
